cube_drop_controller: RTL and testbench

CUBE_DROP_CONTROLLER -- requirements
Module: cube_drop_controller

---
 rtl/falling_cubes_pkg.sv | 30 +++
 rtl/lfsr_posicion.sv | 22 ++
 rtl/cube_drop_controller.sv | 131 +++++++++++++
 tb/tb_cube_drop_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/falling_cubes_pkg.sv
// Shared constants and FSM state type for the falling-cubes game.
package falling_cubes_pkg;

    localparam int unsigned POS_W   = 10;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned VEL_W   = 4;
    localparam int unsigned CHK_W   = 2;

    localparam logic [POS_W-1:0]   ANCHO_CUBO      = 10'd64;
    localparam logic [POS_W-1:0]   ANCHO_CANASTA   = 10'd96;
    localparam logic [POS_W-1:0]   POS_Y_CANASTA   = 10'd436;
    localparam logic [POS_W-1:0]   Y_SPAWN         = 10'd64;
    localparam logic [LIVES_W-1:0] VIDAS_INICIALES = 2'd3;
    localparam logic [VEL_W-1:0]   VEL_MAX         = 4'd8;
    localparam logic [VEL_W-1:0]   VEL_INICIAL     = 4'd1;
    localparam logic [POS_W-1:0]   LFSR_SEED       = 10'h2A5;

    // Cycles spent in CHECK before en_canasta is trusted
    localparam logic [CHK_W-1:0]   CHECK_WAIT      = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        FALL,
        CHECK,
        OVER
    } estado_t;

endpackage

// File: rtl/lfsr_posicion.sv
// 10-bit Fibonacci LFSR (x^10 + x^7 + 1) that free-runs to randomise spawn x.
module lfsr_posicion
    import falling_cubes_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic [POS_W-1:0] valor
);

    logic realimentacion;

    assign realimentacion = valor[9] ^ valor[6];

    always_ff @(posedge clk) begin
        if (reset) begin
            valor <= LFSR_SEED;
        end else begin
            valor <= {valor[8:0], realimentacion};
        end
    end

endmodule

// File: rtl/cube_drop_controller.sv
// Falling-cube game controller: spawn, fall, catch check, score/lives/speed.
// Optional PAUSA_EN adds a pausa input that freezes the cube while falling.
module cube_drop_controller
    import falling_cubes_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               en_canasta,
`ifdef PAUSA_EN
    input  logic               pausa,
`endif
    output logic [POS_W-1:0]   pos_x_cubo,
    output logic [POS_W-1:0]   pos_y_cubo,
    output logic [SCORE_W-1:0] puntaje,
    output logic [LIVES_W-1:0] vidas,
    output logic               cubo_visible,
    output logic               game_over
);

    estado_t            state, state_n;
    logic [POS_W-1:0]   pos_x_n, pos_y_n;
    logic [SCORE_W-1:0] puntaje_n;
    logic [LIVES_W-1:0] vidas_n;
    logic [VEL_W-1:0]   velocidad, velocidad_n;
    logic [1:0]         capturas, capturas_n;
    logic [CHK_W-1:0]   chk_cnt, chk_cnt_n;
    logic               cubo_visible_n, game_over_n;
    logic [POS_W-1:0]   lfsr;
    logic               pausado;

`ifdef PAUSA_EN
    assign pausado = pausa;
`else
    assign pausado = 1'b0;
`endif

    lfsr_posicion u_lfsr (
        .clk   (clk),
        .reset (reset),
        .valor (lfsr)
    );

    // Next-state and next-value logic
    always_comb begin
        state_n     = state;
        pos_x_n     = pos_x_cubo;
        pos_y_n     = pos_y_cubo;
        puntaje_n   = puntaje;
        vidas_n     = vidas;
        velocidad_n = velocidad;
        capturas_n  = capturas;
        chk_cnt_n   = chk_cnt;

        case (state)
            IDLE, OVER: begin
                if (start) begin
                    state_n     = SPAWN;
                    vidas_n     = VIDAS_INICIALES;
                    puntaje_n   = '0;
                    velocidad_n = VEL_INICIAL;
                    capturas_n  = '0;
                end
            end
            SPAWN: begin
                // Top bit cleared keeps the cube fully on screen
                pos_x_n = lfsr & 10'h1FF;
                pos_y_n = Y_SPAWN;
                state_n = FALL;
            end
            FALL: begin
                if (frame_tick && !pausado) begin
                    pos_y_n = pos_y_cubo + POS_W'(velocidad);
                    if (pos_y_n >= POS_Y_CANASTA) begin
                        state_n   = CHECK;
                        chk_cnt_n = '0;
                    end
                end
            end
            CHECK: begin
                if (chk_cnt == CHECK_WAIT) begin
                    if (en_canasta) begin
                        state_n    = SPAWN;
                        puntaje_n  = (puntaje == 8'hFF) ? puntaje : puntaje + 8'd1;
                        capturas_n = capturas + 2'd1;
                        if (capturas == 2'd3 && velocidad < VEL_MAX) begin
                            velocidad_n = velocidad + 4'd1;
                        end
                    end else begin
                        vidas_n = vidas - 2'd1;
                        state_n = (vidas == 2'd1) ? OVER : SPAWN;
                    end
                end else begin
                    chk_cnt_n = chk_cnt + 2'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        cubo_visible_n = (state_n == SPAWN) || (state_n == FALL) || (state_n == CHECK);
        game_over_n    = (state_n == OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pos_x_cubo   <= '0;
            pos_y_cubo   <= '0;
            puntaje      <= '0;
            vidas        <= VIDAS_INICIALES;
            velocidad    <= VEL_INICIAL;
            capturas     <= '0;
            chk_cnt      <= '0;
            cubo_visible <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_n;
            pos_x_cubo   <= pos_x_n;
            pos_y_cubo   <= pos_y_n;
            puntaje      <= puntaje_n;
            vidas        <= vidas_n;
            velocidad    <= velocidad_n;
            capturas     <= capturas_n;
            chk_cnt      <= chk_cnt_n;
            cubo_visible <= cubo_visible_n;
            game_over    <= game_over_n;
        end
    end

endmodule

// File: tb/tb_cube_drop_controller.sv
// Directed self-checking bench for cube_drop_controller (pause test under PAUSA_EN).
module tb_cube_drop_controller;

    logic       clk = 1'b0;
    logic       reset, start, frame_tick, en_canasta;
`ifdef PAUSA_EN
    logic       pausa;
`endif
    logic [9:0] pos_x_cubo, pos_y_cubo;
    logic [7:0] puntaje;
    logic [1:0] vidas;
    logic       cubo_visible, game_over;

    int checks = 0;
    int errors = 0;
    int exp_vel, exp_score, exp_lives, exp_catches;

    always #5 clk = ~clk;

    cube_drop_controller dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .frame_tick   (frame_tick),
        .en_canasta   (en_canasta),
`ifdef PAUSA_EN
        .pausa        (pausa),
`endif
        .pos_x_cubo   (pos_x_cubo),
        .pos_y_cubo   (pos_y_cubo),
        .puntaje      (puntaje),
        .vidas        (vidas),
        .cubo_visible (cubo_visible),
        .game_over    (game_over)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string ctx);
        check({ctx, "_pos_x"}, int'(pos_x_cubo), 0);
        check({ctx, "_pos_y"}, int'(pos_y_cubo), 0);
        check({ctx, "_puntaje"}, int'(puntaje), 0);
        check({ctx, "_vidas"}, int'(vidas), 3);
        check({ctx, "_visible"}, int'(cubo_visible), 0);
        check({ctx, "_game_over"}, int'(game_over), 0);
    endtask

    // Start pulse from IDLE/OVER; ends in FALL with the cube at the spawn height
    task automatic restart();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_vel = 1; exp_score = 0; exp_lives = 3; exp_catches = 0;
        check("spawn_visible", int'(cubo_visible), 1);
        check("spawn_game_over", int'(game_over), 0);
        check("spawn_vidas", int'(vidas), 3);
        check("spawn_puntaje", int'(puntaje), 0);
        step();
        check("fall_pos_y", int'(pos_y_cubo), 64);
        check("fall_pos_x_range", int'(pos_x_cubo[9]), 0);
        check("fall_visible", int'(cubo_visible), 1);
    endtask

    // One full drop from FALL at y=64; start/frame_tick are poked during CHECK
    task automatic drop(input logic catch_it);
        int v, ticks, land;
        v     = exp_vel;
        ticks = (372 + v - 1) / v;
        land  = 64 + ticks * v;
        frame_tick = 1'b1;
        step();
        check("first_step_y", int'(pos_y_cubo), 64 + v);
        repeat (ticks - 1) step();
        check("land_y", int'(pos_y_cubo), land);
        check("check_visible", int'(cubo_visible), 1);
        en_canasta = catch_it;
        start = 1'b1;
        step();
        check("check1_y", int'(pos_y_cubo), land);
        check("check1_puntaje", int'(puntaje), exp_score);
        step();
        start = 1'b0;
        frame_tick = 1'b0;
        check("check2_puntaje", int'(puntaje), exp_score);
        check("check2_vidas", int'(vidas), exp_lives);
        step();
        en_canasta = 1'b0;
        if (catch_it) begin
            if (exp_score < 255) exp_score++;
            exp_catches++;
            if ((exp_catches % 4) == 0 && exp_vel < 8) exp_vel++;
        end else begin
            exp_lives--;
        end
        check("result_puntaje", int'(puntaje), exp_score);
        check("result_vidas", int'(vidas), exp_lives);
        check("result_game_over", int'(game_over), (exp_lives == 0) ? 1 : 0);
        if (exp_lives != 0) begin
            check("respawn_visible", int'(cubo_visible), 1);
            step();
            check("respawn_y", int'(pos_y_cubo), 64);
        end else begin
            check("over_visible", int'(cubo_visible), 0);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            check("over_tick_ignored", int'(pos_y_cubo), land);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0; en_canasta = 1'b0;
`ifdef PAUSA_EN
        pausa = 1'b0;
`endif
        exp_vel = 1; exp_score = 0; exp_lives = 3; exp_catches = 0;
        step();
        step();
        reset = 1'b0;
        check_reset_vals("por");

        frame_tick = 1'b1;
        step();
        step();
        frame_tick = 1'b0;
        check("idle_tick_ignored", int'(pos_y_cubo), 0);
        check("idle_visible", int'(cubo_visible), 0);

        restart();
        for (int i = 0; i < 33; i++) drop(1'b1);
        check("final_score", int'(puntaje), 33);

        for (int i = 0; i < 3; i++) drop(1'b0);

        restart();
        frame_tick = 1'b1;
        repeat (10) step();
        frame_tick = 1'b0;
        check("speed_reloaded", int'(pos_y_cubo), 74);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_vals("mid_fall");

`ifdef PAUSA_EN
        restart();
        pausa = 1'b1;
        frame_tick = 1'b1;
        repeat (10) step();
        frame_tick = 1'b0;
        check("pause_hold_y", int'(pos_y_cubo), 64);
        pausa = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("pause_release_y", int'(pos_y_cubo), 65);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
